pipe_stage_hs: RTL and testbench

Parametrised elastic pipeline register for the RISC-V core, replacing fixed per-boundary latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block. Carries a control bundle and a data bundle through DEPTH register slots with per-slot valid bits and a valid/ready handshake, so stalls back-pressure cleanly instead of overwriting. Adds flush-to-bubble, optional data clearing, and an occupancy count. Sits between any two core stages; the hazard unit drives `flush`.

---
 rtl/riscv_pipe_pkg.sv | 44 ++++
 rtl/pipe_stage_hs_if.sv | 29 ++
 rtl/pipe_stage_hs_slot.sv | 49 ++++
 rtl/pipe_stage_hs.sv | 74 +++++++
 tb/tb_pipe_stage_hs.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared widths and bundle field offsets for the core's pipeline boundary registers.
// Also provides the slot-count helper used by the elastic stage.
package riscv_pipe_pkg;

  localparam int MAX_DEPTH = 8;

  localparam int IDEX_CTRL_W  = 14;
  localparam int IDEX_DATA_W  = 139;
  localparam int EXMEM_CTRL_W = 5;
  localparam int EXMEM_DATA_W = 101;
  localparam int MEMWB_CTRL_W = 2;
  localparam int MEMWB_DATA_W = 69;

  // ID/EX control bundle, LSB first
  localparam int IDEX_C_JALR     = 0;
  localparam int IDEX_C_REGWRITE = 1;
  localparam int IDEX_C_ALUSRC   = 2;
  localparam int IDEX_C_MEMWRITE = 3;
  localparam int IDEX_C_ALUOP    = 4;
  localparam int IDEX_C_ALUOP_W  = 7;
  localparam int IDEX_C_MEMTOREG = 11;
  localparam int IDEX_C_MEMREAD  = 12;
  localparam int IDEX_C_BRANCH   = 13;

  // ID/EX data bundle, LSB first
  localparam int IDEX_D_RS2   = 0;
  localparam int IDEX_D_RS1   = 5;
  localparam int IDEX_D_RD    = 10;
  localparam int IDEX_D_FUNCT = 15;
  localparam int IDEX_D_IMM   = 19;
  localparam int IDEX_D_RD2   = 43;
  localparam int IDEX_D_RD1   = 75;
  localparam int IDEX_D_PC    = 107;

  function automatic logic [3:0] countOnes(input logic [MAX_DEPTH-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/pipe_stage_hs_if.sv
// Handshake bundle between an upstream stage, the elastic register and the downstream stage.
interface pipe_stage_hs_if #(
  parameter int CTRL_W = 14,
  parameter int DATA_W = 139,
  parameter int DEPTH  = 1
) ();
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  count;

  modport master (
    output flush, in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data, count
  );

  modport slave (
    input  flush, in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, count
  );
endinterface

// File: rtl/pipe_stage_hs_slot.sv
// One register slot: valid bit plus control and data bundles.
// An invalid slot always holds zero control so a bubble behaves as a NOP.
module pipe_slot #(
  parameter int CTRL_W     = 14,
  parameter int DATA_W     = 139,
  parameter int CLEAR_DATA = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_load,
  input  logic              i_valid,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);
  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  // Loading a bubble clears control but keeps the old data payload
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      if (CLEAR_DATA != 0) begin
        r_data <= '0;
      end
    end else if (i_load) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_ctrl <= i_ctrl;
        r_data <= i_data;
      end else begin
        r_ctrl <= '0;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_ctrl  = r_ctrl;
  assign o_data  = r_data;
endmodule

// File: rtl/pipe_stage_hs.sv
// Elastic pipeline register of DEPTH slots with valid/ready handshake, flush and occupancy.
// Outputs come straight from the last slot; only the ready chain is combinational.
module pipe_stage_hs
  import riscv_pipe_pkg::*;
#(
  parameter int CTRL_W     = IDEX_CTRL_W,
  parameter int DATA_W     = IDEX_DATA_W,
  parameter int DEPTH      = 1,
  parameter int CLEAR_DATA = 1
) (
  input logic           clk,
  input logic           rst,
  pipe_stage_hs_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]     w_valid;
  logic [DEPTH-1:0]     w_canLoad;
  logic [CTRL_W-1:0]    w_ctrl [DEPTH];
  logic [DATA_W-1:0]    w_data [DEPTH];
  logic [MAX_DEPTH-1:0] w_validPad;

  // A slot can load when any slot from it to the head is empty or the head drains
  always_comb begin
    logic w_anyEmpty;
    w_anyEmpty = bus.out_ready;
    w_canLoad  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_anyEmpty   = w_anyEmpty | ~w_valid[i];
      w_canLoad[i] = w_anyEmpty;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : gSlot
    logic              w_predValid;
    logic [CTRL_W-1:0] w_predCtrl;
    logic [DATA_W-1:0] w_predData;

    if (g == 0) begin : gHead
      assign w_predValid = bus.in_valid;
      assign w_predCtrl  = bus.in_ctrl;
      assign w_predData  = bus.in_data;
    end else begin : gBody
      assign w_predValid = w_valid[g-1];
      assign w_predCtrl  = w_ctrl[g-1];
      assign w_predData  = w_data[g-1];
    end

    pipe_slot #(
      .CTRL_W     (CTRL_W),
      .DATA_W     (DATA_W),
      .CLEAR_DATA (CLEAR_DATA)
    ) uSlot (
      .clk     (clk),
      .rst     (rst),
      .i_flush (bus.flush),
      .i_load  (w_canLoad[g]),
      .i_valid (w_predValid),
      .i_ctrl  (w_predCtrl),
      .i_data  (w_predData),
      .o_valid (w_valid[g]),
      .o_ctrl  (w_ctrl[g]),
      .o_data  (w_data[g])
    );
  end

  assign w_validPad = MAX_DEPTH'(w_valid);

  assign bus.in_ready  = w_canLoad[0];
  assign bus.out_valid = w_valid[DEPTH-1];
  assign bus.out_ctrl  = w_ctrl[DEPTH-1];
  assign bus.out_data  = w_data[DEPTH-1];
  assign bus.count     = CNT_W'(countOnes(w_validPad));
endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed bench for pipe_stage_hs: three instances cover DEPTH 1/3/4 and both data-clear modes.
module tb_pipe_stage_hs;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  pipe_stage_hs_if #(.CTRL_W(14), .DATA_W(139), .DEPTH(1)) if0 ();
  pipe_stage_hs_if #(.CTRL_W(14), .DATA_W(139), .DEPTH(3)) if1 ();
  pipe_stage_hs_if #(.CTRL_W(14), .DATA_W(139), .DEPTH(4)) if2 ();

  pipe_stage_hs #(.CTRL_W(14), .DATA_W(139), .DEPTH(1), .CLEAR_DATA(1)) u0 (
    .clk(clk), .rst(rst), .bus(if0));
  pipe_stage_hs #(.CTRL_W(14), .DATA_W(139), .DEPTH(3), .CLEAR_DATA(1)) u1 (
    .clk(clk), .rst(rst), .bus(if1));
  pipe_stage_hs #(.CTRL_W(14), .DATA_W(139), .DEPTH(4), .CLEAR_DATA(0)) u2 (
    .clk(clk), .rst(rst), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus();
    if0.flush = 0; if0.in_valid = 0; if0.in_ctrl = '0; if0.in_data = '0; if0.out_ready = 0;
    if1.flush = 0; if1.in_valid = 0; if1.in_ctrl = '0; if1.in_data = '0; if1.out_ready = 0;
    if2.flush = 0; if2.in_valid = 0; if2.in_ctrl = '0; if2.in_data = '0; if2.out_ready = 0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    applyStimulus();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;

    // reset state
    checkOutput("rst out_valid", if0.out_valid, 0);
    checkOutput("rst out_ctrl", if0.out_ctrl, 0);
    checkOutput("rst out_data", if0.out_data, 0);
    checkOutput("rst count", if0.count, 0);
    checkOutput("rst in_ready d1", if0.in_ready, 1);
    checkOutput("rst in_ready d3", if1.in_ready, 1);
    checkOutput("rst in_ready d4", if2.in_ready, 1);

    // DEPTH=1 single beat
    if0.in_valid = 1; if0.in_ctrl = 14'h1A5; if0.in_data = 139'h40; if0.out_ready = 1;
    tick();
    if0.in_valid = 0;
    checkOutput("d1 out_valid", if0.out_valid, 1);
    checkOutput("d1 out_ctrl", if0.out_ctrl, 14'h1A5);
    checkOutput("d1 out_data", if0.out_data, 139'h40);
    checkOutput("d1 count", if0.count, 1);
    tick();
    checkOutput("d1 drained valid", if0.out_valid, 0);
    checkOutput("d1 drained ctrl", if0.out_ctrl, 0);
    checkOutput("d1 drained count", if0.count, 0);

    // DEPTH=3 streaming 1..10
    if1.out_ready = 1;
    for (int c = 1; c <= 12; c++) begin
      if (c <= 10) begin
        if1.in_valid = 1; if1.in_data = 139'(c); if1.in_ctrl = 14'(c);
      end else begin
        if1.in_valid = 0;
      end
      #1;
      checkOutput($sformatf("stream in_ready c%0d", c), if1.in_ready, 1);
      tick();
      if (c >= 3) begin
        checkOutput($sformatf("stream valid c%0d", c), if1.out_valid, 1);
        checkOutput($sformatf("stream data c%0d", c), if1.out_data, 139'(c - 2));
      end else begin
        checkOutput($sformatf("stream valid c%0d", c), if1.out_valid, 0);
      end
    end
    tick();
    checkOutput("stream end valid", if1.out_valid, 0);
    checkOutput("stream end count", if1.count, 0);

    // DEPTH=3 stall with four pushes
    if1.out_ready = 0;
    for (int k = 0; k < 4; k++) begin
      if1.in_valid = 1; if1.in_data = 139'(101 + k); if1.in_ctrl = 14'(k + 1);
      #1;
      checkOutput($sformatf("stall in_ready k%0d", k), if1.in_ready, (k < 3) ? 1 : 0);
      tick();
    end
    checkOutput("stall count", if1.count, 3);
    checkOutput("stall head data", if1.out_data, 101);
    checkOutput("stall head ctrl", if1.out_ctrl, 1);
    checkOutput("stall in_ready", if1.in_ready, 0);
    if1.out_ready = 1;
    #1;
    checkOutput("full drain in_ready", if1.in_ready, 1);
    tick();
    if1.in_valid = 0;
    checkOutput("swap head data", if1.out_data, 102);
    checkOutput("swap count", if1.count, 3);
    tick();
    checkOutput("drain data 103", if1.out_data, 103);
    checkOutput("drain count 2", if1.count, 2);
    tick();
    checkOutput("drain data 104", if1.out_data, 104);
    tick();
    checkOutput("drain empty valid", if1.out_valid, 0);
    checkOutput("drain empty ctrl", if1.out_ctrl, 0);

    // DEPTH=3 flush with CLEAR_DATA=1
    if1.out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      if1.in_valid = 1; if1.in_data = 139'(201 + k); if1.in_ctrl = 14'h3FFF;
      tick();
    end
    checkOutput("pre-flush count d3", if1.count, 3);
    if1.flush = 1; if1.in_data = 139'd204; if1.in_ctrl = 14'h5;
    tick();
    if1.flush = 0; if1.in_valid = 0;
    checkOutput("flush count d3", if1.count, 0);
    checkOutput("flush valid d3", if1.out_valid, 0);
    checkOutput("flush ctrl d3", if1.out_ctrl, 0);
    checkOutput("flush data d3", if1.out_data, 0);
    tick();
    checkOutput("flush dropped d3", if1.count, 0);

    // DEPTH=4 bubble collapse under stall
    if2.in_valid = 1; if2.in_data = 139'h55; if2.in_ctrl = 14'h11;
    tick();
    if2.in_valid = 0;
    tick();
    tick();
    checkOutput("collapse not yet", if2.out_valid, 0);
    tick();
    checkOutput("collapse head valid", if2.out_valid, 1);
    checkOutput("collapse head data", if2.out_data, 139'h55);
    checkOutput("collapse count 1", if2.count, 1);
    if2.in_valid = 1; if2.in_data = 139'h66; if2.in_ctrl = 14'h22;
    tick();
    if2.in_valid = 0;
    repeat (3) tick();
    checkOutput("collapse count 2", if2.count, 2);
    checkOutput("collapse head held", if2.out_data, 139'h55);
    if2.out_ready = 1;
    #1;
    checkOutput("collapse in_ready", if2.in_ready, 1);
    tick();
    if2.out_ready = 0;
    checkOutput("collapse second data", if2.out_data, 139'h66);
    checkOutput("collapse second ctrl", if2.out_ctrl, 14'h22);
    checkOutput("collapse after pop", if2.count, 1);

    // DEPTH=4 flush with CLEAR_DATA=0
    if2.in_valid = 1; if2.in_data = 139'h77; if2.in_ctrl = 14'h1;
    tick();
    if2.in_data = 139'h88;
    tick();
    checkOutput("pre-flush count d4", if2.count, 3);
    if2.flush = 1; if2.in_data = 139'h99; if2.in_ctrl = 14'h33;
    tick();
    if2.flush = 0; if2.in_valid = 0;
    checkOutput("flush count d4", if2.count, 0);
    checkOutput("flush valid d4", if2.out_valid, 0);
    checkOutput("flush ctrl d4", if2.out_ctrl, 0);
    checkOutput("flush data held d4", if2.out_data, 139'h66);
    tick();
    checkOutput("flush dropped d4", if2.count, 0);

    // async reset mid-stream, then resume
    if1.out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      if1.in_valid = 1; if1.in_data = 139'(301 + k); if1.in_ctrl = 14'h9;
      tick();
    end
    if1.in_valid = 0;
    checkOutput("pre-rst data", if1.out_data, 301);
    #2 rst = 1'b1;
    #1;
    checkOutput("async rst valid", if1.out_valid, 0);
    checkOutput("async rst data", if1.out_data, 0);
    checkOutput("async rst count", if1.count, 0);
    checkOutput("async rst data d4", if2.out_data, 0);
    #1 rst = 1'b0;
    if1.in_valid = 1; if1.in_data = 139'd401; if1.in_ctrl = 14'h7;
    tick();
    if1.in_valid = 0;
    checkOutput("resume count", if1.count, 1);
    tick();
    tick();
    checkOutput("resume valid", if1.out_valid, 1);
    checkOutput("resume data", if1.out_data, 401);
    checkOutput("resume ctrl", if1.out_ctrl, 14'h7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
